// File: rtl/playback_scheduler_if.sv
// Scheduler-side bundle: keyboard/speed commands in,
// address-controller handshake and status out.
interface playback_scheduler_if;
    logic        kbd_valid;
    logic [7:0]  kbd_char;
    logic        speed_up;
    logic        speed_down;
    logic        speed_reset;
    logic        ctl_finish;
    logic        ctl_start;
    logic        fwd;
    logic        song_restart;
    logic        sample_tick;
    logic        playing;
    logic [15:0] divisor;
    logic        overrun;

    modport master (
        output kbd_valid, kbd_char,
        output speed_up, speed_down, speed_reset,
        output ctl_finish,
        input  ctl_start, fwd, song_restart,
        input  sample_tick, playing, divisor, overrun
    );

    modport slave (
        input  kbd_valid, kbd_char,
        input  speed_up, speed_down, speed_reset,
        input  ctl_finish,
        output ctl_start, fwd, song_restart,
        output sample_tick, playing, divisor, overrun
    );
endinterface

// File: rtl/playback_scheduler.sv
// Sample-rate divider and start/finish sequencer for the
// flash-sample address controller.
module playback_scheduler #(
    parameter int unsigned DIV_DEFAULT = 2272,
    parameter int unsigned DIV_MIN     = 568,
    parameter int unsigned DIV_MAX     = 9088,
    parameter int unsigned DIV_STEP    = 32
) (
    input logic clk,
    input logic reset,
    playback_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, ISSUE, BUSY} state_t;

    localparam logic [16:0] L_MIN  = 17'(DIV_MIN);
    localparam logic [16:0] L_MAX  = 17'(DIV_MAX);
    localparam logic [16:0] L_STEP = 17'(DIV_STEP);
    localparam logic [15:0] L_DEF  = 16'(DIV_DEFAULT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] r_div;
    logic        r_fwd;
    logic        r_fwd_req;
    logic        r_pause_pend;
    logic        r_restart_pend;
    logic        r_restart;
    logic        r_overrun;

    logic        w_tick;
    logic [7:0]  w_lc;
    logic        w_play;
    logic        w_pause;
    logic        w_fcmd;
    logic        w_bcmd;
    logic        w_rcmd;
    logic        w_fwd_req_nxt;
    logic        w_idle_arm;
    logic        w_inflight;
    logic        w_done;
    logic [16:0] w_up;
    logic [16:0] w_dn;

    assign w_tick = r_cnt >= (r_div - 16'd1);

    // Setting bit 5 folds upper case onto lower case for letters.
    assign w_lc    = bus.kbd_char | 8'h20;
    assign w_play  = bus.kbd_valid && (w_lc == 8'h65);
    assign w_pause = bus.kbd_valid && (w_lc == 8'h64);
    assign w_fcmd  = bus.kbd_valid && (w_lc == 8'h66);
    assign w_bcmd  = bus.kbd_valid && (w_lc == 8'h62);
    assign w_rcmd  = bus.kbd_valid && (w_lc == 8'h72);

    assign w_fwd_req_nxt = w_fcmd ? 1'b1 :
                           w_bcmd ? 1'b0 : r_fwd_req;

    assign w_idle_arm = (r_state == IDLE) || (r_state == ARM);
    assign w_inflight = (r_state == ISSUE) || (r_state == BUSY);
    assign w_done     = (r_state == BUSY) && bus.ctl_finish;

    assign w_up = {1'b0, r_div} - L_STEP;
    assign w_dn = {1'b0, r_div} + L_STEP;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_play) w_state_nxt = ARM;
            end
            ARM: begin
                if (w_pause)     w_state_nxt = IDLE;
                else if (w_tick) w_state_nxt = ISSUE;
            end
            ISSUE: w_state_nxt = BUSY;
            BUSY: begin
                if (bus.ctl_finish) begin
                    if ((r_pause_pend || w_pause) && !w_play)
                        w_state_nxt = IDLE;
                    else
                        w_state_nxt = ARM;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_div          <= L_DEF;
            r_fwd          <= 1'b1;
            r_fwd_req      <= 1'b1;
            r_pause_pend   <= 1'b0;
            r_restart_pend <= 1'b0;
            r_restart      <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_tick ? 16'd0 : r_cnt + 16'd1;
            r_fwd_req <= w_fwd_req_nxt;
            // Direction is frozen while a read is in flight.
            if (w_idle_arm) r_fwd <= w_fwd_req_nxt;

            if (!w_inflight || w_done) r_pause_pend <= 1'b0;
            else if (w_pause)          r_pause_pend <= 1'b1;
            else if (w_play)           r_pause_pend <= 1'b0;

            if (!w_inflight || w_done) r_restart_pend <= 1'b0;
            else if (w_rcmd)           r_restart_pend <= 1'b1;

            r_restart <= (w_idle_arm && w_rcmd) ||
                         (w_done && (r_restart_pend || w_rcmd));

            if (w_tick && w_inflight) r_overrun <= 1'b1;

            if (bus.speed_reset)
                r_div <= L_DEF;
            else if (bus.speed_up && !bus.speed_down)
                r_div <= (w_up < L_MIN) ? L_MIN[15:0] : w_up[15:0];
            else if (bus.speed_down && !bus.speed_up)
                r_div <= (w_dn > L_MAX) ? L_MAX[15:0] : w_dn[15:0];
        end
    end

    assign bus.ctl_start    = (r_state == ISSUE);
    assign bus.fwd          = r_fwd;
    assign bus.song_restart = r_restart;
    assign bus.sample_tick  = w_tick;
    assign bus.playing      = (r_state != IDLE) && !r_pause_pend;
    assign bus.divisor      = r_div;
    assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_playback_scheduler.sv
// Directed bench for playback_scheduler: divider, start/finish
// sequencing, direction hold, restart, overrun and speed limits.
module tb_playback_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;

    int   n_start = 0;
    int   n_tick = 0;
    int   n_rst = 0;
    int   n_orphan = 0;
    int   n_wide = 0;
    logic p_tick = 1'b0;
    logic p_start = 1'b0;

    int   k;
    int   s_st;
    int   s_tk;
    int   s_r;

    playback_scheduler_if bus();

    playback_scheduler dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Event counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.ctl_start) begin
            n_start++;
            if (!p_tick) n_orphan++;
            if (p_start) n_wide++;
        end
        if (bus.sample_tick)  n_tick++;
        if (bus.song_restart) n_rst++;
        p_tick  = bus.sample_tick;
        p_start = bus.ctl_start;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] c);
        bus.kbd_char  = c;
        bus.kbd_valid = 1'b1;
        @(negedge clk);
        bus.kbd_valid = 1'b0;
        bus.kbd_char  = 8'h00;
    endtask

    task automatic speed(input logic u, input logic d, input logic r);
        bus.speed_up    = u;
        bus.speed_down  = d;
        bus.speed_reset = r;
        @(negedge clk);
        bus.speed_up    = 1'b0;
        bus.speed_down  = 1'b0;
        bus.speed_reset = 1'b0;
    endtask

    task automatic finish_pulse();
        bus.ctl_finish = 1'b1;
        @(negedge clk);
        bus.ctl_finish = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int lim);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ctl_start && n < lim);
        chk(tag, bus.ctl_start, 1);
    endtask

    task automatic wait_tick(output int n, input int lim);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_tick && n < lim);
        chk("tick_seen", bus.sample_tick, 1);
    endtask

    initial begin
        bus.kbd_valid   = 1'b0;
        bus.kbd_char    = 8'h00;
        bus.speed_up    = 1'b0;
        bus.speed_down  = 1'b0;
        bus.speed_reset = 1'b0;
        bus.ctl_finish  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_fwd", bus.fwd, 1);
        chk("rst_playing", bus.playing, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_divisor", bus.divisor, 2272);
        chk("rst_start", bus.ctl_start, 0);
        chk("rst_restart", bus.song_restart, 0);
        reset = 1'b0;

        s_st = n_start;
        s_tk = n_tick;
        repeat (3000) @(negedge clk);
        chk("idle_starts", n_start - s_st, 0);
        chk("idle_ticks", n_tick - s_tk, 1);
        chk("idle_fwd", bus.fwd, 1);

        wait_tick(k, 3000);
        wait_tick(k, 3000);
        chk("tick_period", k, 2272);

        // Play lands on a tick cycle: that tick is not used.
        send_key(8'h45);
        chk("play_on", bus.playing, 1);
        chk("play_no_start", bus.ctl_start, 0);
        s_st = n_start;
        s_tk = n_tick;
        for (int i = 0; i < 3; i++) begin
            wait_start("run_start", 2400);
            repeat (20) @(negedge clk);
            finish_pulse();
        end
        repeat (5) @(negedge clk);
        chk("run_starts", n_start - s_st, 3);
        chk("run_ticks", n_tick - s_tk, 3);
        chk("run_overrun", bus.overrun, 0);

        wait_start("b_start", 2400);
        repeat (2) @(negedge clk);
        send_key(8'h42);
        repeat (3) @(negedge clk);
        chk("fwd_busy", bus.fwd, 1);
        finish_pulse();
        chk("fwd_fin", bus.fwd, 1);
        @(negedge clk);
        chk("fwd_arm", bus.fwd, 0);

        wait_start("r_start", 2400);
        repeat (2) @(negedge clk);
        send_key(8'h52);
        send_key(8'h52);
        s_r = n_rst;
        repeat (10) @(negedge clk);
        chk("rst_busy_quiet", bus.song_restart, 0);
        finish_pulse();
        chk("rst_after_fin", bus.song_restart, 1);
        @(negedge clk);
        chk("rst_fin_end", bus.song_restart, 0);
        chk("rst_once", n_rst - s_r, 1);
        send_key(8'h72);
        chk("rst_arm", bus.song_restart, 1);
        @(negedge clk);
        chk("rst_arm_end", bus.song_restart, 0);
        chk("rst_total", n_rst - s_r, 2);

        wait_start("ov_start", 2400);
        s_st = n_start;
        repeat (5000) @(negedge clk);
        chk("ov_no_start", n_start - s_st, 0);
        chk("ov_set", bus.overrun, 1);
        finish_pulse();
        repeat (10) @(negedge clk);
        chk("ov_sticky", bus.overrun, 1);

        wait_start("d_start", 2400);
        repeat (2) @(negedge clk);
        send_key(8'h64);
        chk("d_pend_play", bus.playing, 0);
        finish_pulse();
        chk("d_idle_play", bus.playing, 0);
        s_st = n_start;
        repeat (5000) @(negedge clk);
        chk("d_no_start", n_start - s_st, 0);

        repeat (53) speed(1'b1, 1'b0, 1'b0);
        chk("spd_up53", bus.divisor, 576);
        repeat (7) speed(1'b1, 1'b0, 1'b0);
        chk("spd_min", bus.divisor, 568);
        repeat (300) speed(1'b0, 1'b1, 1'b0);
        chk("spd_max", bus.divisor, 9088);
        speed(1'b1, 1'b1, 1'b0);
        chk("spd_both", bus.divisor, 9088);
        speed(1'b1, 1'b0, 1'b0);
        chk("spd_down1", bus.divisor, 9056);
        speed(1'b1, 1'b0, 1'b1);
        chk("spd_reset", bus.divisor, 2272);

        chk("start_orphan", n_orphan, 0);
        chk("start_wide", n_wide, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/playback_scheduler.md
Name: playback_scheduler

Overview:
- Sequences the flash-sample address controller for audio playback.
- Generates the sample-rate strobe that clocks the address controller's byte reads.
- Issues one start pulse per sample period while playing, and tracks completion.
- Translates keyboard commands (play/pause/direction/restart) and speed buttons into a stable FWD level, a restart pulse and a programmable sample divisor.

Parameters:
DIV_DEFAULT, 2272, reset/default clocks per sample period (50 MHz / ~22 kHz)
DIV_MIN, 568, minimum divisor (fastest playback)
DIV_MAX, 9088, maximum divisor (slowest playback)
DIV_STEP, 32, divisor change per speed button pulse

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
kbd_valid  input  1  one-cycle strobe, kbd_char valid
kbd_char  input  8  ASCII key code
speed_up  input  1  one-cycle pulse, decrease divisor
speed_down  input  1  one-cycle pulse, increase divisor
speed_reset  input  1  one-cycle pulse, divisor := DIV_DEFAULT
ctl_finish  input  1  address controller finish pulse
ctl_start  output  1  one-cycle start pulse to address controller
fwd  output  1  direction to address controller; 1 = forward
song_restart  output  1  one-cycle restart pulse to address controller
sample_tick  output  1  one-cycle sample strobe (drives clk_synced)
playing  output  1  1 while not paused
divisor  output  16  current divisor
overrun  output  1  sticky; a tick arrived while a read was outstanding

Behaviour:
- Reset values:
  - all pulses 0; fwd=1; playing=0; overrun=0; divisor=DIV_DEFAULT.
  - divider cnt=0; state=IDLE; all pending flags cleared.
  - Reset mid-operation abandons any outstanding read; the datapath is cleared by system reset separately.
- Divider: free-running 16-bit cnt, runs in every state.
  - When cnt >= divisor-1: sample_tick=1 that cycle and cnt<=0; otherwise cnt<=cnt+1.
  - The >= compare makes a shrunk divisor tick immediately and never stall.
- Keyboard decode applies only when kbd_valid=1; upper- and lower-case both accepted; all other codes are ignored.
  - E/e (0x45/0x65): play.
  - D/d (0x44/0x64): pause.
  - F/f (0x46/0x66): fwd_req=1.
  - B/b (0x42/0x62): fwd_req=0.
  - R/r (0x52/0x72): restart request.
- fwd output loads fwd_req only in IDLE or ARM.
  - fwd is held constant through ISSUE and BUSY, because the controller samples direction mid-operation.
- FSM states: IDLE, ARM, ISSUE, BUSY.
  - IDLE (playing=0): play -> ARM.
  - ARM (playing=1): pause -> IDLE; else sample_tick -> ISSUE.
  - ISSUE: ctl_start=1 for exactly this cycle -> BUSY.
  - BUSY: waits for ctl_finish.
    - On ctl_finish: -> IDLE if pause_pending, else ARM; pause_pending cleared.
    - Pause in BUSY or ISSUE sets pause_pending; an in-flight read is never aborted.
    - Play while pause_pending clears pause_pending.
  - playing=1 in ARM/ISSUE/BUSY unless pause_pending.
- Restart:
  - In IDLE or ARM: song_restart=1 on the cycle after the command.
  - In ISSUE/BUSY: sets restart_pending; song_restart=1 on the cycle after ctl_finish, then cleared.
  - Repeated R while pending produces a single pulse.
- Overrun: sample_tick while state is ISSUE or BUSY sets overrun (sticky until reset). That tick is dropped, not queued.
- Speed control (at most one action per cycle; priority speed_reset > up/down):
  - speed_reset: divisor := DIV_DEFAULT.
  - speed_up alone: divisor := max(divisor-DIV_STEP, DIV_MIN).
  - speed_down alone: divisor := min(divisor+DIV_STEP, DIV_MAX).
  - speed_up and speed_down together: no change.
  - Arithmetic is 17-bit before saturation, so no wrap.
- Simultaneous events:
  - play and tick in the same IDLE cycle: go to ARM; the tick is not used.
  - pause and tick in ARM: pause wins (-> IDLE, no start).
  - ctl_finish arriving outside BUSY is ignored.

Test Plan:
- Reset, wait 3000 cycles -> ctl_start never asserts; sample_tick every 2272 cycles; fwd=1; divisor=2272.
- 'E', then ctl_finish returned 20 cycles after each ctl_start -> exactly one 1-cycle ctl_start per tick, 1 cycle after the tick; overrun stays 0.
- Playing, 'B' sent while BUSY -> fwd stays 1 until ctl_finish, then 0 before the next ctl_start; 'D' in BUSY -> finish completes, state IDLE, no further starts.
- 'R' while BUSY -> song_restart pulses exactly once, the cycle after ctl_finish; 'R' in ARM -> pulse on the next cycle.
- 60 speed_up pulses -> divisor saturates at 568; 300 speed_down pulses -> 9088; up+down in the same cycle -> unchanged; speed_reset -> 2272.
- ctl_finish withheld for 5000 cycles while playing -> overrun=1 and stays 1; no extra ctl_start until finish arrives.
